read_counter_sequencer: RTL and testbench

//  Digital side of the CDU angle-read loop. Owns the 16-bit read counter (1 LSB = 360/65536 deg)
//  and decodes it into the active-low switch selects _D1.._D14 that steer the quadrant selector.

---
 rtl/cdu_pkg.sv | 39 +++
 rtl/switch_select_decode.sv | 29 ++
 rtl/read_counter_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_read_counter_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdu_pkg.sv
// ---------------------------------------------------------------------------
// cdu_pkg : shared types and constants for the CDU read-counter loop. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cdu_pkg;

  localparam int CNT_W = 16;
  localparam int D_W   = 14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STEP   = 3'd4
  } state_e;

  localparam int D1  = 0;
  localparam int D2  = 1;
  localparam int D3  = 2;
  localparam int D4  = 3;
  localparam int D5  = 4;
  localparam int D6  = 5;
  localparam int D7  = 6;
  localparam int D8  = 7;
  localparam int D9  = 8;
  localparam int D10 = 9;
  localparam int D11 = 10;
  localparam int D12 = 11;
  localparam int D13 = 12;
  localparam int D14 = 13;

  // Switch selects for cnt=0 in fine mode (bit i is _D(i+1))
  localparam logic [D_W-1:0] D_RESET = 14'h32AE;

endpackage

`default_nettype wire

// File: rtl/switch_select_decode.sv
// ---------------------------------------------------------------------------
// switch_select_decode : cnt[15:11] + mode -> active-low selects _D1.._D14. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module switch_select_decode
  import cdu_pkg::*;
(
  input  logic [4:0]     cnt_hi_i,
  input  logic           coarse_i,
  output logic [D_W-1:0] d_o
);

  always_comb begin
    d_o          = '1;
    d_o[D4:D1]   = ~(4'b0001 << cnt_hi_i[2:1]);
    d_o[D5]      = cnt_hi_i[4];
    d_o[D7]      = cnt_hi_i[4] ^ cnt_hi_i[3];
    d_o[D9]      = coarse_i;
    d_o[D10]     = ~coarse_i;
    d_o[D11]     = cnt_hi_i[0];
    d_o[D12]     = coarse_i;
    d_o[D13]     = ~coarse_i;
    d_o[D14]     = ~cnt_hi_i[0];
  end

endmodule

`default_nettype wire

// File: rtl/read_counter_sequencer.sv
// ---------------------------------------------------------------------------
// read_counter_sequencer : CDU angle-read counter, null-seeking step loop. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module read_counter_sequencer
  import cdu_pkg::*;
#(
  parameter int SETTLE     = 4,
  parameter int COARSE_DIV = 8,
  parameter int FINE_DIV   = 32,
  parameter int LOCK_CNT   = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             zero_req,
  input  logic             cmp_coarse_hi,
  input  logic             cmp_coarse_lo,
  input  logic             cmp_fine_hi,
  input  logic             cmp_fine_lo,
  output logic             _D1,
  output logic             _D2,
  output logic             _D3,
  output logic             _D4,
  output logic             _D5,
  output logic             _D6,
  output logic             _D7,
  output logic             _D8,
  output logic             _D9,
  output logic             _D10,
  output logic             _D11,
  output logic             _D12,
  output logic             _D13,
  output logic             _D14,
  output logic [CNT_W-1:0] cnt,
  output logic             up_pulse,
  output logic             dn_pulse,
  output logic             coarse,
  output logic             locked,
  output logic             cmp_err
);

  // SETTLE state lasts SETTLE+1 cycles: one extra for the decode register to
  // present the new selects, so comparators always see SETTLE settled cycles.
  localparam int MIN_PER = SETTLE + 3;
  localparam int PER_C   = (COARSE_DIV > MIN_PER) ? COARSE_DIV : MIN_PER;
  localparam int PER_F   = (FINE_DIV > MIN_PER) ? FINE_DIV : MIN_PER;
  localparam int TMR_W   = 16;

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE);
  localparam logic [TMR_W-1:0] WAIT_C      = TMR_W'(PER_C - MIN_PER);
  localparam logic [TMR_W-1:0] WAIT_F      = TMR_W'(PER_F - MIN_PER);
  localparam logic [TMR_W-1:0] LOCK_SAT    = TMR_W'(LOCK_CNT);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [TMR_W-1:0]   lockcnt_q, lockcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_up_q, dir_up_d;
  logic               up_q, up_d;
  logic               dn_q, dn_d;
  logic               coarse_q, coarse_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic [D_W-1:0]     dsel_q, dsel_d;
  logic               samp_hi, samp_lo;
  logic [TMR_W-1:0]   wait_len;

  switch_select_decode u_decode (
    .cnt_hi_i (cnt_q[CNT_W-1:CNT_W-5]),
    .coarse_i (coarse_q),
    .d_o      (dsel_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      lockcnt_q <= '0;
      cnt_q     <= '0;
      dir_up_q  <= 1'b0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      coarse_q  <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      dsel_q    <= D_RESET;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      lockcnt_q <= lockcnt_d;
      cnt_q     <= cnt_d;
      dir_up_q  <= dir_up_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      coarse_q  <= coarse_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      dsel_q    <= dsel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    lockcnt_d = lockcnt_q;
    cnt_d     = cnt_q;
    dir_up_d  = dir_up_q;
    up_d      = 1'b0;
    dn_d      = 1'b0;
    coarse_d  = coarse_q;
    locked_d  = locked_q;
    err_d     = err_q;
    samp_hi   = 1'b0;
    samp_lo   = 1'b0;
    wait_len  = coarse_q ? WAIT_C : WAIT_F;

    if (zero_req) begin
      cnt_d     = '0;
      lockcnt_d = '0;
      locked_d  = 1'b0;
      err_d     = 1'b0;
      tmr_d     = '0;
      state_d   = enable ? ST_SETTLE : ST_IDLE;
    end else if (!enable) begin
      lockcnt_d = '0;
      locked_d  = 1'b0;
      state_d   = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tmr_d   = '0;
          state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (tmr_q == SETTLE_LAST) state_d = ST_SAMPLE;
          else                      tmr_d   = tmr_q + 16'd1;
        end
        ST_SAMPLE: begin
          coarse_d = cmp_coarse_hi | cmp_coarse_lo;
          samp_hi  = coarse_d ? cmp_coarse_hi : cmp_fine_hi;
          samp_lo  = coarse_d ? cmp_coarse_lo : cmp_fine_lo;
          if (!coarse_d && !cmp_fine_hi && !cmp_fine_lo)
            lockcnt_d = (lockcnt_q >= LOCK_SAT) ? LOCK_SAT : lockcnt_q + 16'd1;
          else
            lockcnt_d = '0;
          locked_d = (lockcnt_d >= LOCK_SAT);
          if (samp_hi && samp_lo) err_d = 1'b1;
          tmr_d = '0;
          // A mode change only moves the selects; stepping resumes after they settle.
          if ((coarse_d == coarse_q) && (samp_hi ^ samp_lo)) begin
            dir_up_d = samp_hi;
            state_d  = (wait_len == '0) ? ST_STEP : ST_WAIT;
          end else begin
            state_d = ST_SETTLE;
          end
        end
        ST_WAIT: begin
          if (tmr_q == wait_len - 16'd1) state_d = ST_STEP;
          else                           tmr_d   = tmr_q + 16'd1;
        end
        ST_STEP: begin
          cnt_d    = dir_up_q ? cnt_q + 16'd1 : cnt_q - 16'd1;
          up_d     = dir_up_q;
          dn_d     = ~dir_up_q;
          locked_d = 1'b0;
          tmr_d    = '0;
          state_d  = ST_SETTLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign cnt      = cnt_q;
  assign up_pulse = up_q;
  assign dn_pulse = dn_q;
  assign coarse   = coarse_q;
  assign locked   = locked_q;
  assign cmp_err  = err_q;

  assign _D1  = dsel_q[D1];
  assign _D2  = dsel_q[D2];
  assign _D3  = dsel_q[D3];
  assign _D4  = dsel_q[D4];
  assign _D5  = dsel_q[D5];
  assign _D6  = dsel_q[D6];
  assign _D7  = dsel_q[D7];
  assign _D8  = dsel_q[D8];
  assign _D9  = dsel_q[D9];
  assign _D10 = dsel_q[D10];
  assign _D11 = dsel_q[D11];
  assign _D12 = dsel_q[D12];
  assign _D13 = dsel_q[D13];
  assign _D14 = dsel_q[D14];

endmodule

`default_nettype wire

// File: tb/tb_read_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_read_counter_sequencer : randomized bench against a timing-level reference model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_read_counter_sequencer;

  localparam int SETTLE     = 4;
  localparam int COARSE_DIV = 8;
  localparam int FINE_DIV   = 32;
  localparam int LOCK_CNT   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0, zero_req = 1'b0;
  logic chi = 1'b0, clo = 1'b0, fhi = 1'b0, flo = 1'b0;
  logic _D1, _D2, _D3, _D4, _D5, _D6, _D7, _D8, _D9, _D10, _D11, _D12, _D13, _D14;
  logic [15:0] cnt;
  logic up_pulse, dn_pulse, coarse, locked, cmp_err;
  logic [13:0] dvec;

  always #5 clk = ~clk;

  read_counter_sequencer #(
    .SETTLE(SETTLE), .COARSE_DIV(COARSE_DIV), .FINE_DIV(FINE_DIV), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .zero_req(zero_req),
    .cmp_coarse_hi(chi), .cmp_coarse_lo(clo), .cmp_fine_hi(fhi), .cmp_fine_lo(flo),
    ._D1(_D1), ._D2(_D2), ._D3(_D3), ._D4(_D4), ._D5(_D5), ._D6(_D6), ._D7(_D7),
    ._D8(_D8), ._D9(_D9), ._D10(_D10), ._D11(_D11), ._D12(_D12), ._D13(_D13), ._D14(_D14),
    .cnt(cnt), .up_pulse(up_pulse), .dn_pulse(dn_pulse),
    .coarse(coarse), .locked(locked), .cmp_err(cmp_err)
  );

  assign dvec = {_D14, _D13, _D12, _D11, _D10, _D9, _D8, _D7, _D6, _D5, _D4, _D3, _D2, _D1};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: time offset m_t inside a step period starting at entry to settling.
  int          m_cnt = 0, m_lock = 0, m_t = 0, m_dir = 0;
  bit          m_coarse = 0, m_locked = 0, m_err = 0, m_up = 0, m_dn = 0, m_active = 0;
  logic [13:0] m_d;

  function automatic logic [13:0] ref_decode(input int c, input bit crs);
    logic [13:0] d;
    d = '1;
    d[(c >> 12) & 3] = 1'b0;
    d[4]  = c[15];
    d[6]  = c[15] ^ c[14];
    d[10] = c[11];
    d[13] = ~c[11];
    d[8]  = crs;
    d[9]  = ~crs;
    d[11] = crs;
    d[12] = ~crs;
    return d;
  endfunction

  function automatic int period(input bit crs);
    int div;
    div = crs ? COARSE_DIV : FINE_DIV;
    return (div > SETTLE + 3) ? div : SETTLE + 3;
  endfunction

  task automatic model_step();
    bit nc, hi, lo;
    m_d  = ref_decode(m_cnt, m_coarse);
    m_up = 0;
    m_dn = 0;
    if (zero_req) begin
      m_cnt = 0; m_lock = 0; m_locked = 0; m_err = 0;
      m_active = enable; m_t = 0; m_dir = 0;
    end else if (!enable) begin
      m_active = 0; m_lock = 0; m_locked = 0; m_dir = 0;
    end else if (!m_active) begin
      m_active = 1; m_t = 0;
    end else if (m_t == SETTLE + 1) begin
      nc = chi | clo;
      hi = nc ? chi : fhi;
      lo = nc ? clo : flo;
      if (!nc && !fhi && !flo) m_lock = (m_lock < LOCK_CNT) ? m_lock + 1 : LOCK_CNT;
      else                     m_lock = 0;
      m_locked = (m_lock >= LOCK_CNT);
      if (hi && lo) m_err = 1;
      if (nc == m_coarse && hi != lo) begin
        m_dir = hi ? 1 : -1;
        m_t++;
      end else begin
        m_dir = 0;
        m_t = 0;
      end
      m_coarse = nc;
    end else if (m_dir != 0 && m_t == period(m_coarse) - 1) begin
      m_cnt = (m_cnt + m_dir) & 32'hFFFF;
      m_up = (m_dir > 0);
      m_dn = (m_dir < 0);
      m_locked = 0; m_dir = 0; m_t = 0;
    end else begin
      m_t++;
    end
  endtask

  always @(posedge clk) if (!rst) model_step();

  task automatic compare_all();
    check_eq("cnt", cnt, m_cnt);
    check_eq("up_pulse", up_pulse, m_up);
    check_eq("dn_pulse", dn_pulse, m_dn);
    check_eq("coarse", coarse, m_coarse);
    check_eq("locked", locked, m_locked);
    check_eq("cmp_err", cmp_err, m_err);
    check_eq("dsel", dvec, m_d);
    check_eq("pulse_excl", up_pulse & dn_pulse, 0);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_cmp(input logic ch, input logic cl, input logic fh, input logic fl);
    chi = ch; clo = cl; fhi = fh; flo = fl;
  endtask

  logic [31:0] r;
  bit          seen;

  initial begin
    m_d = ref_decode(0, 0);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b0;

    // Null inputs: fine mode, lock accumulates
    enable = 1'b1;
    for (int i = 0; i < 20 * (SETTLE + 2) + 10; i++) tick();
    check_eq("locked_after_null", locked, 1);

    // Coarse up stepping
    set_cmp(1, 0, 0, 0);
    for (int i = 0; i < 90; i++) tick();
    check_eq("coarse_mode", coarse, 1);

    // Zero, one fine down step to 0xFFFF, then one fine up step back to 0x0000
    zero_req = 1'b1; tick(); zero_req = 1'b0;
    set_cmp(0, 0, 0, 1);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (dn_pulse) seen = 1;
    end
    check_eq("down_wrap_seen", seen, 1);
    check_eq("cnt_ffff", cnt, 16'hFFFF);
    set_cmp(0, 0, 1, 0);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (up_pulse) seen = 1;
    end
    check_eq("up_wrap_seen", seen, 1);
    check_eq("cnt_wrap_zero", cnt, 0);

    // Coarse down through the top quadrant
    set_cmp(0, 1, 0, 0);
    for (int i = 0; i < 60; i++) tick();

    // zero_req exactly in a step cycle
    set_cmp(1, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (m_dir != 0 && m_t == period(m_coarse) - 1) begin
        zero_req = 1'b1; seen = 1;
      end
    end
    check_eq("zero_in_step_hit", seen, 1);
    tick(); zero_req = 1'b0;
    check_eq("zero_in_step_cnt", cnt, 0);
    check_eq("zero_in_step_pulse", up_pulse | dn_pulse, 0);
    for (int i = 0; i < 30; i++) tick();

    // enable low mid-wait
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (m_dir != 0 && m_t == SETTLE + 2 && m_t < period(m_coarse) - 1) begin
        enable = 1'b0; seen = 1;
      end
    end
    check_eq("enable_drop_hit", seen, 1);
    tick(); enable = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // Fine pair contradiction
    set_cmp(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    set_cmp(0, 0, 1, 1);
    for (int i = 0; i < 40; i++) tick();
    check_eq("fine_cmp_err", cmp_err, 1);
    zero_req = 1'b1; tick(); zero_req = 1'b0;
    check_eq("err_cleared", cmp_err, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      zero_req = ($urandom_range(0, 49) == 0);
      enable   = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom;
        set_cmp(r[0] & r[4], r[1] & r[5] & r[6], r[2], r[3] & r[7]);
      end
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
